// File: rtl/cache_pkg.sv
// cache_pkg: line/burst geometry and adapter state shared by the L2 control and datapath.
package cache_pkg;
  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int ADDR_WIDTH  = 32;
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_WIDTH   = $clog2(BEATS);
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} adapter_state_t;
endpackage

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: turns one 256-bit L2 line read/writeback into a 4-beat 64-bit memory burst.
module cacheline_adapter
  import cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   read_i,
  input  logic                   write_i,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  output logic                   resp_o,
  output logic                   read_o,
  output logic                   write_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  input  logic                   resp_i
);
  adapter_state_t        r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [LINE_WIDTH-1:0] r_line;
  logic [LINE_WIDTH-1:0] r_wline;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_aligned;
  assign w_last    = resp_i && (r_cnt == CNT_WIDTH'(BEATS - 1));
  assign w_aligned = address_i & ~ADDR_WIDTH'((1 << OFFSET_BITS) - 1);
  // Writeback data lives apart from the fill buffer so line_o stays put across a writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_line  <= '0;
      r_wline <= '0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: if (read_i || write_i) begin
          r_addr  <= w_aligned;
          r_cnt   <= '0;
          r_state <= read_i ? RD_BURST : WR_BURST;
          if (!read_i) r_wline <= line_i;
        end
        RD_BURST: if (resp_i) begin
          r_line[r_cnt*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= DONE;
        end
        WR_BURST: if (resp_i) begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= DONE;
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign read_o    = r_state == RD_BURST;
  assign write_o   = r_state == WR_BURST;
  assign resp_o    = r_state == DONE;
  assign address_o = (read_o || write_o) ? r_addr : '0;
  assign burst_o   = write_o ? r_wline[r_cnt*BURST_WIDTH +: BURST_WIDTH] : '0;
  assign line_o    = r_line;
endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter: directed bursts checked every cycle against driver-side expectations.
module tb_cacheline_adapter;
  import cache_pkg::*;
  logic clk = 0, rst = 0, read_i = 0, write_i = 0, resp_i = 0;
  logic resp_o, read_o, write_o;
  logic [31:0] address_i = 0, address_o;
  logic [255:0] line_i = 0, line_o;
  logic [63:0] burst_i = 0, burst_o;
  logic e_rd = 0, e_wr = 0, e_resp = 0;
  logic [31:0] e_addr = 0;
  logic [63:0] e_burst = 0;
  logic [255:0] e_line = 0;
  int checks = 0, errors = 0, cyc = 0, lat;
  bit chk_en = 1;
  logic [31:0] addr_seen;
  localparam logic [255:0] FILL1 = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
  localparam logic [255:0] WB1   = {{4{16'hD3D3}}, {4{16'hD2D2}}, {4{16'hD1D1}}, {4{16'hD0D0}}};
  localparam logic [255:0] FILL2 = {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001};
  localparam logic [255:0] FILL3 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'hA5A5_5A5A_A5A5_5A5A, 64'h0F0F_F0F0_0F0F_F0F0};
  cacheline_adapter dut (
    .clk(clk), .rst(rst), .read_i(read_i), .write_i(write_i), .address_i(address_i),
    .line_i(line_i), .line_o(line_o), .resp_o(resp_o), .read_o(read_o), .write_o(write_o),
    .address_o(address_o), .burst_i(burst_i), .burst_o(burst_o), .resp_i(resp_i)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("read_o", 256'(read_o), 256'(e_rd));
    chk("write_o", 256'(write_o), 256'(e_wr));
    chk("resp_o", 256'(resp_o), 256'(e_resp));
    chk("address_o", 256'(address_o), 256'(e_addr));
    chk("burst_o", 256'(burst_o), 256'(e_burst));
    chk("line_o", line_o, e_line);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] junk();
    return {$urandom, $urandom};
  endfunction
  task automatic do_read(input logic [31:0] a, input logic [255:0] d, input int gap,
                         input bit both, input bit stray, output int l, output logic [31:0] aseen);
    int t0;
    read_i = 1; write_i = both; address_i = a; line_i = {4{junk()}}; resp_i = stray; burst_i = junk();
    step();
    t0 = cyc; resp_i = 0; aseen = address_o;
    e_rd = 1; e_addr = a & ~32'h1f;
    address_i = $urandom; line_i = {4{junk()}};
    for (int b = 0; b < 4; b++) begin
      repeat (gap) begin burst_i = junk(); step(); end
      burst_i = d[b*64 +: 64]; resp_i = 1;
      step();
      resp_i = 0; burst_i = junk();
      e_line[b*64 +: 64] = d[b*64 +: 64];
      if (b == 3) begin e_rd = 0; e_addr = 0; e_resp = 1; end
    end
    l = cyc - t0 + 1;
    step();
    e_resp = 0; read_i = 0; write_i = 0;
  endtask
  task automatic do_write(input logic [31:0] a, input logic [255:0] d, input int gap);
    write_i = 1; read_i = 0; address_i = a; line_i = d;
    step();
    e_wr = 1; e_addr = a & ~32'h1f;
    address_i = $urandom; line_i = {4{junk()}};
    for (int b = 0; b < 4; b++) begin
      e_burst = d[b*64 +: 64];
      repeat (gap) begin resp_i = 0; step(); end
      resp_i = 1;
      step();
      resp_i = 0;
    end
    e_wr = 0; e_addr = 0; e_burst = 0; e_resp = 1;
    step();
    e_resp = 0; write_i = 0;
  endtask
  initial begin
    #2;
    chk("rst_read_o", 256'(read_o), 256'(0));
    chk("rst_line_o", line_o, 256'(0));
    chk("rst_addr_o", 256'(address_o), 256'(0));
    #12 rst = 1;
    step();
    do_read(32'h0000_1234, FILL1, 0, 0, 0, lat, addr_seen);
    chk("fill_latency", 256'(lat), 256'(5));
    chk("fill_addr", 256'(addr_seen), 256'(32'h0000_1220));
    chk("fill_line", line_o, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
    do_write(32'h0000_8008, WB1, 0);
    chk("wb_keeps_line", line_o, FILL1);
    do_read(32'h0000_9000, FILL2, 0, 0, 0, lat, addr_seen);
    chk("dirty_miss_line", line_o, FILL2);
    do_write(32'h7FFF_FFFF, FILL1, 3);
    do_read(32'hFFFF_FFE1, FILL3, 3, 0, 0, lat, addr_seen);
    chk("stall_latency", 256'(lat), 256'(17));
    chk("stall_line", line_o, FILL3);
    read_i = 1; address_i = 32'hABCD_0047;
    step();
    e_rd = 1; e_addr = 32'hABCD_0040;
    for (int b = 0; b < 2; b++) begin
      burst_i = 64'hBAD0_0000_0000_0000 | 64'(b); resp_i = 1;
      step();
      resp_i = 0;
      e_line[b*64 +: 64] = 64'hBAD0_0000_0000_0000 | 64'(b);
    end
    #1 rst = 0; read_i = 0;
    e_rd = 0; e_addr = 0; e_line = 0;
    #1;
    chk("async_read_o", 256'(read_o), 256'(0));
    chk("async_addr_o", 256'(address_o), 256'(0));
    chk("async_line_o", line_o, 256'(0));
    chk("async_resp_o", 256'(resp_o), 256'(0));
    step(); step();
    rst = 1;
    step();
    do_read(32'hABCD_0040, FILL2, 0, 0, 0, lat, addr_seen);
    chk("post_rst_line", line_o, FILL2);
    resp_i = 1;
    step();
    resp_i = 0;
    do_read(32'h0000_0100, FILL3, 1, 1, 1, lat, addr_seen);
    chk("both_req_line", line_o, FILL3);
    chk("both_req_addr", 256'(addr_seen), 256'(32'h0000_0100));
    step();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule
